pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage RV32 pipeline.
- Generates per-stage stall and flush controls and EX-stage forwarding selects.
- Adds load-use interlock, branch/jump flush and multi-cycle data-memory wait, none of which the current pipeline has.
- Memory latency is parametrised: fixed-latency counter mode or ready-handshake mode.
- Includes saturating performance counters.
- Sits beside the pipeline registers and drives their enable/clear inputs.

Parameters:
REG_ADDR_W, 5, register index width
MEM_MODE, 0, 0 = fixed memory latency MEM_LAT; 1 = variable latency via mem_ready
MEM_LAT, 1, total cycles a memory access occupies MEM in mode 0; legal range 1..16; 1 = no stall
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs1_D, rs2_D  in  REG_ADDR_W  source registers in ID
rs1_E, rs2_E  in  REG_ADDR_W  source registers in EX
rd_E, rd_M, rd_W  in  REG_ADDR_W  destination registers in EX/MEM/WB
RegWrite_M, RegWrite_W  in  1  write enables in MEM/WB
MemRead_E  in  1  load in EX (ResultSrc_E == 2'b01)
PCSrc_E  in  2  non-zero = taken branch/jump redirect
MemReq_M  in  1  load or store in MEM
mem_ready  in  1  data memory completes this cycle (mode 1 only; ignored in mode 0)
Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold stage register / PC
Flush_D, Flush_E, Flush_W  out  1  clear pipeline register to bubble
ForwardA_E, ForwardB_E  out  2  00 = regfile, 01 = Result_W, 10 = ALUResult_M
busy  out  1  FSM not in RUN
stall_cycles  out  CNT_W  cycles with Stall_F = 1
flush_count  out  CNT_W  branch flush events

Behaviour:
Reset
- One clock; reset is synchronous and active-high.
- While rst = 1: all stall/flush outputs = 0, forwards = 00, busy = 0.
- Next state is RUN, cnt = 0, both counters = 0.
- Reset mid-WAIT abandons the wait; no stall in the cycle after reset deasserts unless new conditions hold.

FSM states: RUN, WAIT, RELEASE (RELEASE used in mode 0 only). mem_stall is Mealy.

Mode 0
- RUN & MemReq_M & MEM_LAT > 1: mem_stall = 1; cnt <= MEM_LAT-2; next = RELEASE if MEM_LAT == 2, else WAIT.
- WAIT: mem_stall = 1; cnt <= cnt-1; next = RELEASE when cnt == 1.
- RELEASE: mem_stall = 0 regardless of MemReq_M; next = RUN.
- Net effect: exactly MEM_LAT-1 stall cycles per access.
- Back-to-back accesses each take the full latency.

Mode 1
- RUN & MemReq_M & !mem_ready: mem_stall = 1; next = WAIT.
- WAIT: mem_stall = !mem_ready. When mem_ready = 1: next = RUN, and the instruction advances that same cycle.
- RUN & MemReq_M & mem_ready: no stall.

mem_stall (highest priority)
- Stall_F = Stall_D = Stall_E = Stall_M = 1, Flush_W = 1.
- Flush_D = Flush_E = 0.
- A redirect pending in EX is held and acted on the first non-stalled cycle.
- PC update in IF is gated by Stall_F, overriding PCSrc_E.

Branch (PCSrc_E != 0, no mem_stall)
- Flush_D = Flush_E = 1, Stall_F = Stall_D = 0.
- Overrides load-use, since the instruction in D is wrong-path.

Load-use (no mem_stall, no branch)
- Condition: MemRead_E & rd_E != 0 & (rd_E == rs1_D | rd_E == rs2_D).
- Response: Stall_F = Stall_D = 1, Flush_E = 1; exactly one bubble.

Forwarding (combinational, independent of stalls; shown for A, B identical using rs2_E)
- 10 if RegWrite_M & rd_M != 0 & rd_M == rs1_E.
- Else 01 if RegWrite_W & rd_W != 0 & rd_W == rs1_E.
- Else 00.
- MEM has priority over WB.

Counters
- stall_cycles increments on every cycle with Stall_F = 1.
- flush_count increments on every cycle with branch-caused Flush_D.
- Both saturate at all-ones and never wrap.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in D -> one cycle Stall_F = Stall_D = Flush_E = 1; next cycle ForwardA_E = 01; stall_cycles = 1.
- rd_M = 3 & RegWrite_M, rd_W = 3 & RegWrite_W, rs1_E = 3 -> ForwardA_E = 10. With rd_M = 0 and rd_W = 0: ForwardA_E = 00.
- PCSrc_E = 01 together with a load-use condition -> Flush_D = Flush_E = 1, Stall_F = 0; flush_count = 1.
- MEM_MODE 0, MEM_LAT = 4, MemReq_M held high -> all stalls and Flush_W high exactly 3 cycles, busy high 3 cycles, then 1 cycle free. Second access repeats the pattern; stall_cycles = 6.
- MEM_MODE 1, mem_ready low 5 cycles then high -> stall 5 cycles, released in the ready cycle. A concurrent PCSrc_E != 0 produces no Flush_D until the release cycle.
- rst asserted during WAIT (MEM_LAT = 8, cycle 3) -> outputs 0 that cycle, state RUN, counters 0. CNT_W = 4 with 20 stalls -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: interlocks, branch flush,
// data-memory wait FSM, EX forwarding selects and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_MODE   = 0,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rs1_E,
    input  logic [REG_ADDR_W-1:0] rs2_E,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic                  RegWrite_M,
    input  logic                  RegWrite_W,
    input  logic                  MemRead_E,
    input  logic [1:0]            PCSrc_E,
    input  logic                  MemReq_M,
    input  logic                  mem_ready,
    output logic                  Stall_F,
    output logic                  Stall_D,
    output logic                  Stall_E,
    output logic                  Stall_M,
    output logic                  Flush_D,
    output logic                  Flush_E,
    output logic                  Flush_W,
    output logic [1:0]            ForwardA_E,
    output logic [1:0]            ForwardB_E,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int CW = 5;

    typedef enum logic [1:0] {RUN, WAIT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_stall;
    logic            load_use, branch;
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    // mem_stall is Mealy: the first access cycle stalls before the FSM leaves RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        if (MEM_MODE == 0) begin
            case (state_q)
                RUN: if (MemReq_M && MEM_LAT > 1) begin
                    mem_stall = 1'b1;
                    cnt_d     = CW'(MEM_LAT - 2);
                    state_d   = (MEM_LAT == 2) ? RELEASE : WAIT;
                end
                WAIT: begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = RELEASE;
                end
                default: state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN: if (MemReq_M && !mem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                end
                WAIT: begin
                    mem_stall = !mem_ready;
                    if (mem_ready) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_use = MemRead_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    assign branch   = (PCSrc_E != 2'b00);

    // Priority: memory wait freezes everything, a redirect beats load-use (D is wrong-path).
    always_comb begin
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Flush_W    = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (!rst) begin
            if (mem_stall) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else if (branch) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
            if (RegWrite_M && rd_M != '0 && rd_M == rs1_E)      ForwardA_E = 2'b10;
            else if (RegWrite_W && rd_W != '0 && rd_W == rs1_E) ForwardA_E = 2'b01;
            if (RegWrite_M && rd_M != '0 && rd_M == rs2_E)      ForwardB_E = 2'b10;
            else if (RegWrite_W && rd_W != '0 && rd_W == rs2_E) ForwardB_E = 2'b01;
        end
    end

    assign busy = !rst && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (Stall_F && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (Flush_D && flush_count_q != '1)  flush_count_q  <= flush_count_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed bench: three controller configurations share one stimulus
// stream and are compared every cycle against a behavioural hazard model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       RegWrite_M, RegWrite_W, MemRead_E, MemReq_M, mem_ready;
    logic [1:0] PCSrc_E;

    // flags: {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, busy}
    logic [7:0]  fl0, fl1, fl2;
    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    int nchk = 0, nfail = 0;

    always #5 clk = ~clk;

    // u0: fixed latency 4, u1: ready handshake, u2: fixed latency 8 with 4-bit counters
    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_MODE(0), .MEM_LAT(4), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .mem_ready(mem_ready),
        .Stall_F(fl0[7]), .Stall_D(fl0[6]), .Stall_E(fl0[5]), .Stall_M(fl0[4]),
        .Flush_D(fl0[3]), .Flush_E(fl0[2]), .Flush_W(fl0[1]), .busy(fl0[0]),
        .ForwardA_E(fa0), .ForwardB_E(fb0), .stall_cycles(sc0), .flush_count(fc0));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_MODE(1), .MEM_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .mem_ready(mem_ready),
        .Stall_F(fl1[7]), .Stall_D(fl1[6]), .Stall_E(fl1[5]), .Stall_M(fl1[4]),
        .Flush_D(fl1[3]), .Flush_E(fl1[2]), .Flush_W(fl1[1]), .busy(fl1[0]),
        .ForwardA_E(fa1), .ForwardB_E(fb1), .stall_cycles(sc1), .flush_count(fc1));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_MODE(0), .MEM_LAT(8), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E), .MemReq_M(MemReq_M), .mem_ready(mem_ready),
        .Stall_F(fl2[7]), .Stall_D(fl2[6]), .Stall_E(fl2[5]), .Stall_M(fl2[4]),
        .Flush_D(fl2[3]), .Flush_E(fl2[2]), .Flush_W(fl2[1]), .busy(fl2[0]),
        .ForwardA_E(fa2), .ForwardB_E(fb2), .stall_cycles(sc2), .flush_count(fc2));

    // Model state: remaining cycles of the current fixed-latency access, handshake wait flag.
    int     p0 = 0, p2 = 0;
    bit     w1 = 0;
    longint msc[3], mfc[3];
    longint mx[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (RegWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (RegWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
    function automatic logic [6:0] exp7(input bit ms);
        bit lu;
        lu = MemRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        if (rst)          return 7'b0000000;
        if (ms)           return 7'b1111001;
        if (PCSrc_E != 0) return 7'b0000110;
        if (lu)           return 7'b1100010;
        return 7'b0000000;
    endfunction

    task automatic tick();
        bit          ms[3];
        bit          bz[3];
        logic [6:0]  e[3];
        #2;
        ms[0] = !rst && ((p0 == 0 && MemReq_M) || p0 > 1);
        ms[1] = !rst && (w1 || MemReq_M) && !mem_ready;
        ms[2] = !rst && ((p2 == 0 && MemReq_M) || p2 > 1);
        bz[0] = !rst && p0 != 0;
        bz[1] = !rst && w1;
        bz[2] = !rst && p2 != 0;
        for (int k = 0; k < 3; k++) e[k] = exp7(ms[k]);
        chk("flags0", 64'(fl0), 64'({e[0], bz[0]}));
        chk("flags1", 64'(fl1), 64'({e[1], bz[1]}));
        chk("flags2", 64'(fl2), 64'({e[2], bz[2]}));
        chk("fwdA", 64'({fa0, fa1, fa2}), 64'({3{fwd(rs1_E)}}));
        chk("fwdB", 64'({fb0, fb1, fb2}), 64'({3{fwd(rs2_E)}}));
        chk("stall_cnt0", 64'(sc0), 64'(msc[0]));
        chk("stall_cnt1", 64'(sc1), 64'(msc[1]));
        chk("stall_cnt2", 64'(sc2), 64'(msc[2]));
        chk("flush_cnt", {fc0, fc1}, {32'(mfc[0]), 32'(mfc[1])});
        chk("flush_cnt2", 64'(fc2), 64'(mfc[2]));
        @(posedge clk);
        if (rst) begin
            p0 = 0; p2 = 0; w1 = 0;
            for (int k = 0; k < 3; k++) begin msc[k] = 0; mfc[k] = 0; end
        end else begin
            if (p0 != 0) p0--; else if (MemReq_M) p0 = 3;
            if (p2 != 0) p2--; else if (MemReq_M) p2 = 7;
            w1 = ms[1];
            for (int k = 0; k < 3; k++) begin
                if (e[k][6] && msc[k] < mx[k]) msc[k]++;
                if (e[k][2] && mfc[k] < mx[k]) mfc[k]++;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        RegWrite_M = 0; RegWrite_W = 0; MemRead_E = 0; PCSrc_E = 0; MemReq_M = 0; mem_ready = 0;
    endtask

    task automatic do_rst();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin msc[k] = 0; mfc[k] = 0; end
        tick();                               // reset-state check
        rst = 0;

        // load-use: lw x5 in EX, add x6,x5,x1 in D, then forward from WB
        MemRead_E = 1; rd_E = 5; rs1_D = 5; rs2_D = 1; tick();
        idle(); rs1_E = 5; rd_W = 5; RegWrite_W = 1; tick();
        chk("lu_fwdA", 64'(fa0), 64'd1);
        chk("lu_stall_cnt", 64'(sc0), 64'd1);

        // MEM beats WB, x0 never forwards
        idle(); rd_M = 3; RegWrite_M = 1; rd_W = 3; RegWrite_W = 1; rs1_E = 3; tick();
        chk("fwd_mem_prio", 64'(fa0), 64'd2);
        rd_M = 0; rd_W = 0; tick();
        chk("fwd_x0", 64'(fa0), 64'd0);

        // branch overrides load-use
        do_rst();
        PCSrc_E = 2'b01; MemRead_E = 1; rd_E = 7; rs2_D = 7; tick();
        chk("br_flush_cnt", 64'(fc0), 64'd1);
        chk("br_no_stall", 64'(sc0), 64'd0);

        // back-to-back fixed-latency accesses
        do_rst();
        MemReq_M = 1; mem_ready = 1;
        repeat (8) tick();
        chk("lat4_stall_cnt", 64'(sc0), 64'd6);

        // handshake wait with a pending redirect held until release
        do_rst();
        MemReq_M = 1; mem_ready = 0; PCSrc_E = 2'b10;
        repeat (5) tick();
        mem_ready = 1; tick();
        chk("hs_stall_cnt", 64'(sc1), 64'd5);
        chk("hs_flush_cnt", 64'(fc1), 64'd1);

        // reset in the middle of a long wait
        do_rst();
        MemReq_M = 1;
        repeat (3) tick();
        rst = 1; tick();
        rst = 0; MemReq_M = 0; tick();
        chk("rst_wait_cnt", 64'(sc2), 64'd0);

        // 4-bit counter saturation
        do_rst();
        MemRead_E = 1; rd_E = 9; rs1_D = 9;
        repeat (20) tick();
        chk("sat_stall_cnt", 64'(sc2), 64'd15);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            rs1_E      = 5'($urandom_range(0, 3));
            rs2_E      = 5'($urandom_range(0, 3));
            rd_E       = 5'($urandom_range(0, 3));
            rd_M       = 5'($urandom_range(0, 3));
            rd_W       = 5'($urandom_range(0, 3));
            RegWrite_M = 1'($urandom);
            RegWrite_W = 1'($urandom);
            MemRead_E  = ($urandom_range(0, 2) == 0);
            PCSrc_E    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            MemReq_M   = ($urandom_range(0, 2) == 0);
            mem_ready  = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
